// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding and debounce defaults.
package stopwatch_pkg;

    localparam int unsigned DEB_CYCLES_DEFAULT = 500000;
    localparam int unsigned CNT_W_DEFAULT      = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_FULL = 2'd3
    } sw_state_t;

endpackage

// File: rtl/key_debounce.sv
// Raw push-button conditioning: 2-flop synchronizer, stability-window debounce,
// one-cycle pulse on each debounced press (0->1 only).
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic KEY_IN,
    output logic PRESS
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             deb_q;
    logic             deb_prev_q;
    logic [CNT_W-1:0] cnt_q;

    // Level accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            sync_q     <= 2'b00;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
            PRESS      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], KEY_IN};
            deb_prev_q <= deb_q;
            PRESS      <= deb_q & ~deb_prev_q;
            if (sync_q[1] != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_q <= sync_q[1];
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: debounced start/stop and reset keys drive PAUSE/CLR/RUN_LED.
// Optional lap-hold feature enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W      = CNT_W_DEFAULT
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic KEY_START,
    input  logic KEY_RESET,
    input  logic WARN,
`ifdef STOPWATCH_LAP_EN
    input  logic KEY_LAP,
    output logic LAP_HOLD,
`endif
    output logic PAUSE,
    output logic CLR,
    output logic RUN_LED
);

    sw_state_t state_q;
    sw_state_t state_d;
    logic      start_press;
    logic      reset_press;
    logic      pause_d;
    logic      clr_d;
    logic      run_led_d;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_start (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .KEY_IN (KEY_START),
        .PRESS  (start_press)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_reset (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .KEY_IN (KEY_RESET),
        .PRESS  (reset_press)
    );

    // State and registered outputs; CLR held high through reset to clear the counter.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= ST_IDLE;
            PAUSE   <= 1'b1;
            CLR     <= 1'b1;
            RUN_LED <= 1'b0;
        end else begin
            state_q <= state_d;
            PAUSE   <= pause_d;
            CLR     <= clr_d;
            RUN_LED <= run_led_d;
        end
    end

    // Reset key dominates; in RUN a full-scale WARN outranks a start press.
    always_comb begin
        state_d = state_q;
        if (reset_press) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_press) state_d = ST_RUN;
                ST_RUN: begin
                    if (WARN)             state_d = ST_FULL;
                    else if (start_press) state_d = ST_STOP;
                end
                ST_STOP: if (start_press) state_d = ST_RUN;
                ST_FULL: state_d = ST_FULL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the next state so they land with the state change.
    always_comb begin
        pause_d   = 1'b1;
        clr_d     = 1'b0;
        run_led_d = 1'b0;
        pause_d   = (state_d != ST_RUN);
        run_led_d = (state_d == ST_RUN);
        clr_d     = reset_press;
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_press;
    logic lap_hold_d;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_lap (
        .CLK    (CLK),
        .CLR_N  (CLR_N),
        .KEY_IN (KEY_LAP),
        .PRESS  (lap_press)
    );

    // Lap toggles only while staying in RUN; leaving to IDLE/STOP releases the display.
    always_comb begin
        lap_hold_d = LAP_HOLD;
        if (state_d == ST_IDLE || state_d == ST_STOP) begin
            lap_hold_d = 1'b0;
        end else if (lap_press && state_q == ST_RUN && state_d == ST_RUN) begin
            lap_hold_d = ~LAP_HOLD;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            LAP_HOLD <= 1'b0;
        end else begin
            LAP_HOLD <= lap_hold_d;
        end
    end
`else
    // No lap path: the display always follows the counter.
`endif

endmodule
